mc_ctrl: RTL and testbench

Multi-cycle MIPS main controller sequencing the shared datapath (one ALU, one unified memory, register file). Decodes the opcode once per instruction, walks a Moore FSM and drives every datapath mux select plus all architectural write enables. Sits beside the datapath top. Optionally waits on a memory-ready handshake for slow memory.

---
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller.
// A Moore FSM that sequences the shared ALU, the unified memory and the
// register file. It drives every datapath mux select and all write enables.
// Define MEM_HANDSHAKE_EN to make FETCH, MEMRD and MEMWR wait for mem_ready.
// Without that macro every memory state lasts one cycle and mem_ready is
// ignored.
module mc_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       regdst,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic       retire,
   output logic       illegal
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEXEC,
      S_ADDIWB,
      S_JUMP
   } state_t;

   state_t state;

   // mem_done is high in the cycle in which the current memory access
   // completes. It is always high when there is no handshake.
   logic mem_done;
`ifdef MEM_HANDSHAKE_EN
   assign mem_done = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_done         = 1'b1;
`endif

   // State sequencing and the sticky illegal-opcode flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_FETCH:  if (mem_done) state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_EXEC;
                  OP_BEQ:       state <= S_BRANCH;
                  OP_ADDI:      state <= S_ADDIEXEC;
                  OP_J:         state <= S_JUMP;
                  default: begin
                     // Unsupported opcode: flag it and carry on with
                     // the next fetch.
                     state   <= S_FETCH;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_MEMADR:   state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_done) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWR:    if (mem_done) state <= S_FETCH;
            S_EXEC:     state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_ADDIEXEC: state <= S_ADDIWB;
            S_ADDIWB:   state <= S_FETCH;
            S_JUMP:     state <= S_FETCH;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Output decode of the state register. Reset masks every write enable
   // and mem_req. The selects already show FETCH values because the state
   // is FETCH during reset.
   always_comb begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      pcsrc    = 2'b00;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      retire   = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_done;
            pcen    = mem_done;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = mem_done;
            retire   = mem_done;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            pcen    = zero;
            retire  = 1'b1;
         end
         S_ADDIEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         S_JUMP: begin
            pcsrc  = 2'b10;
            pcen   = 1'b1;
            retire = 1'b1;
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
      if (!rst_n) begin
         mem_req  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         pcen     = 1'b0;
         retire   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl. The DUT outputs are packed into one
// 16-bit word in this order: {mem_req, iord, alusrca, alusrcb, aluop, pcsrc,
// regdst, memtoreg, irwrite, memwrite, regwrite, pcen, retire}. Each word is
// compared against hand-written per-state constants.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'b000000;
   logic       zero = 1'b0;
`ifdef MEM_HANDSHAKE_EN
   logic       mem_ready = 1'b1;
`else
   logic       mem_ready = 1'b0;
`endif
   logic       mem_req, iord, alusrca, regdst, memtoreg;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       irwrite, memwrite, regwrite, pcen, retire, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [15:0] C_RESET    = 16'b0_0_0_01_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_FETCH    = 16'b1_0_0_01_00_00_0_0_1_0_0_1_0;
   localparam logic [15:0] C_FHOLD    = 16'b1_0_0_01_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_DECODE   = 16'b0_0_0_11_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_MEMADR   = 16'b0_0_1_10_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_MEMRD    = 16'b1_1_0_00_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_MEMWB    = 16'b0_0_0_00_00_00_0_1_0_0_1_0_1;
   localparam logic [15:0] C_MEMWR    = 16'b1_1_0_00_00_00_0_0_0_1_0_0_1;
   localparam logic [15:0] C_WRHOLD   = 16'b1_1_0_00_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_EXEC     = 16'b0_0_1_00_10_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_ALUWB    = 16'b0_0_0_00_00_00_1_0_0_0_1_0_1;
   localparam logic [15:0] C_BR_Z1    = 16'b0_0_1_00_01_01_0_0_0_0_0_1_1;
   localparam logic [15:0] C_BR_Z0    = 16'b0_0_1_00_01_01_0_0_0_0_0_0_1;
   localparam logic [15:0] C_ADDIEXEC = 16'b0_0_1_10_00_00_0_0_0_0_0_0_0;
   localparam logic [15:0] C_ADDIWB   = 16'b0_0_0_00_00_00_0_0_0_0_1_0_1;
   localparam logic [15:0] C_JUMP     = 16'b0_0_0_00_00_10_0_0_0_0_0_1_1;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic [15:0] obs;
   assign obs = {mem_req, iord, alusrca, alusrcb, aluop, pcsrc,
                 regdst, memtoreg, irwrite, memwrite, regwrite, pcen, retire};

   mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
      .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .pcen(pcen), .retire(retire), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      #1;
      n_checks++;
      if (obs !== C_RESET) begin
         n_fail++; $display("FAIL reset_outputs: got %b required %b", obs, C_RESET);
      end
      n_checks++;
      if (illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_illegal: got %b required 0", illegal);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== C_RESET) begin
         n_fail++; $display("FAIL reset_held: got %b required %b", obs, C_RESET);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      $display("reset released");
   endtask

   task automatic test_lw();
      logic [15:0] seq [5];
      seq = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
      op = OP_LW;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (obs !== seq[i]) begin
            n_fail++; $display("FAIL lw cycle %0d: got %b required %b", i, obs, seq[i]);
         end
         @(posedge clk); #1;
      end
      $display("lw done");
   endtask

   task automatic test_branch(input logic zero_val);
      logic [15:0] seq [3];
      seq = '{C_FETCH, C_DECODE, (zero_val ? C_BR_Z1 : C_BR_Z0)};
      op   = OP_BEQ;
      zero = zero_val;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (obs !== seq[i]) begin
            n_fail++; $display("FAIL beq_z%0d cycle %0d: got %b required %b", zero_val, i, obs, seq[i]);
         end
         if (i == 2) begin
            zero = ~zero_val;
            #1;
            n_checks++;
            if (pcen !== ~zero_val) begin
               n_fail++; $display("FAIL beq_pcen_follows_zero: got %b required %b", pcen, ~zero_val);
            end
            zero = zero_val;
            #1;
         end
         @(posedge clk); #1;
      end
      $display("beq zero=%0d done", zero_val);
   endtask

   task automatic test_illegal();
      logic [15:0] seq [6];
      logic [5:0]  ops [6];
      seq = '{C_FETCH, C_DECODE, C_FETCH, C_DECODE, C_EXEC, C_ALUWB};
      ops = '{OP_BAD, OP_BAD, OP_R, OP_R, OP_R, OP_R};
      n_checks++;
      if (illegal !== 1'b0) begin
         n_fail++; $display("FAIL illegal_before: got %b required 0", illegal);
      end
      for (int i = 0; i < 6; i++) begin
         op = ops[i];
         #1;
         n_checks++;
         if (obs !== seq[i]) begin
            n_fail++; $display("FAIL illegal_seq cycle %0d: got %b required %b", i, obs, seq[i]);
         end
         if (i >= 2) begin
            n_checks++;
            if (illegal !== 1'b1) begin
               n_fail++; $display("FAIL illegal_sticky cycle %0d: got %b required 1", i, illegal);
            end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (illegal !== 1'b1) begin
         n_fail++; $display("FAIL illegal_after_r: got %b required 1", illegal);
      end
      $display("illegal op done");
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq [11];
      logic [5:0]  ops [11];
      seq = '{C_FETCH, C_DECODE, C_ADDIEXEC, C_ADDIWB,
              C_FETCH, C_DECODE, C_JUMP,
              C_FETCH, C_DECODE, C_MEMADR, C_MEMWR};
      ops = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
              OP_J, OP_J, OP_J,
              OP_SW, OP_SW, OP_SW, OP_SW};
      for (int i = 0; i < 11; i++) begin
         op = ops[i];
         #1;
         n_checks++;
         if (obs !== seq[i]) begin
            n_fail++; $display("FAIL b2b cycle %0d: got %b required %b", i, obs, seq[i]);
         end
         @(posedge clk); #1;
      end
      $display("addi/j/sw back to back done");
   endtask

`ifdef MEM_HANDSHAKE_EN
   task automatic test_handshake();
      logic [15:0] seq [17];
      logic [5:0]  ops [17];
      logic        rdy [17];
      seq = '{C_FETCH, C_DECODE, C_MEMADR, C_WRHOLD, C_WRHOLD, C_WRHOLD, C_MEMWR,
              C_FHOLD, C_FETCH, C_DECODE, C_JUMP,
              C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMWB};
      ops = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW,
              OP_J, OP_J, OP_J, OP_J,
              OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b1, 1'b1, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 17; i++) begin
         op        = ops[i];
         mem_ready = rdy[i];
         #1;
         n_checks++;
         if (obs !== seq[i]) begin
            n_fail++; $display("FAIL handshake cycle %0d: got %b required %b", i, obs, seq[i]);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      $display("handshake sw/j/lw done");
   endtask
`endif

   task automatic test_reset_mid();
      logic [15:0] seq [4];
      seq = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD};
      op = OP_LW;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (obs !== seq[i]) begin
            n_fail++; $display("FAIL reset_mid_lw cycle %0d: got %b required %b", i, obs, seq[i]);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (regwrite !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_memwb_regwrite: got %b required 1", regwrite);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (regwrite !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_regwrite_drop: got %b required 0", regwrite);
      end
      n_checks++;
      if (obs !== C_RESET) begin
         n_fail++; $display("FAIL reset_mid_outputs: got %b required %b", obs, C_RESET);
      end
      n_checks++;
      if (illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_illegal: got %b required 0", illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (obs !== C_FETCH) begin
         n_fail++; $display("FAIL reset_mid_restart_fetch: got %b required %b", obs, C_FETCH);
      end
      @(posedge clk); #1;
      n_checks++;
      if (obs !== C_DECODE) begin
         n_fail++; $display("FAIL reset_mid_restart_decode: got %b required %b", obs, C_DECODE);
      end
      $display("mid-instruction reset done");
   endtask

   initial begin
      test_reset();
      test_lw();
      test_branch(1'b1);
      test_branch(1'b0);
      test_illegal();
      test_back_to_back();
`ifdef MEM_HANDSHAKE_EN
      test_handshake();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
